// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: word type,
// fetch FSM encoding and the default fetch address window.
package fetch_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEF_RESET_PC = 32'h0000_3000;
    localparam word_t DEF_IMEM_LO  = 32'h0000_3000;
    localparam word_t DEF_IMEM_HI  = 32'h0000_6FFC;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port: the fetch stage is the master and the
// memory is the slave. The response comes back as a single-cycle ack.
interface fetch_ctrl_if;

    logic                  imem_req;
    fetch_ctrl_pkg::word_t imem_addr;
    logic                  imem_ack;
    fetch_ctrl_pkg::word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_addr_chk.sv
// Fetch address legality: word aligned and inside the instruction window.
// The bounds are compared as unsigned values.
module fetch_addr_chk
    import fetch_ctrl_pkg::*;
#(
    parameter word_t LO = DEF_IMEM_LO,
    parameter word_t HI = DEF_IMEM_HI
) (
    input  word_t addr,
    output logic  legal
);

    assign legal = (addr[1:0] == 2'b00) && (addr >= LO) && (addr <= HI);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage controller: issues instruction reads, holds one fetched slot for
// D, honours delayed-branch redirects and turns illegal fetches into AdEL slots.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter word_t RESET_PC = DEF_RESET_PC,
    parameter word_t IMEM_LO  = DEF_IMEM_LO,
    parameter word_t IMEM_HI  = DEF_IMEM_HI
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  word_t        redirect_pc,
    fetch_ctrl_if.master imem,
    output word_t        F_PC,
    output word_t        F_instr,
    output logic         F_valid,
    output logic         F_exc
);

    fetch_state_e state;
    word_t        req_pc;
    logic         pend;
    word_t        pend_pc;

    logic  redir_acc;
    word_t nxt;
    word_t req_follow;
    logic  req_legal;
    logic  nxt_legal;

    // A redirect under stall is dropped; D keeps presenting it until it moves.
    assign redir_acc = redirect && !stall;
    assign nxt       = redir_acc ? redirect_pc : req_pc;

    // Address fetched after the slot completing in S_REQ: a same-cycle redirect
    // wins over one latched earlier, which wins over sequential flow.
    assign req_follow = redir_acc ? redirect_pc
                      : pend      ? pend_pc
                      :             req_pc + 32'd4;

    fetch_addr_chk #(.LO(IMEM_LO), .HI(IMEM_HI)) u_chk_req (
        .addr  (req_pc),
        .legal (req_legal)
    );

    fetch_addr_chk #(.LO(IMEM_LO), .HI(IMEM_HI)) u_chk_nxt (
        .addr  (nxt),
        .legal (nxt_legal)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = req_pc;
        if (state == S_REQ) begin
            imem.imem_req = reset && req_legal;
        end else begin
            imem.imem_addr = nxt;
            imem.imem_req  = reset && !stall && nxt_legal;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_REQ;
            req_pc  <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= '0;
            F_PC    <= RESET_PC;
            F_instr <= '0;
            F_valid <= 1'b0;
            F_exc   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!req_legal || imem.imem_ack) begin
                        F_PC    <= req_pc;
                        F_instr <= req_legal ? imem.imem_rdata : '0;
                        F_exc   <= !req_legal;
                        F_valid <= 1'b1;
                        req_pc  <= req_follow;
                        pend    <= 1'b0;
                        state   <= S_HOLD;
                    end else if (redir_acc) begin
                        pend    <= 1'b1;
                        pend_pc <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if (!nxt_legal || imem.imem_ack) begin
                            F_PC    <= nxt;
                            F_instr <= nxt_legal ? imem.imem_rdata : '0;
                            F_exc   <= !nxt_legal;
                            F_valid <= 1'b1;
                            req_pc  <= nxt + 32'd4;
                        end else begin
                            // Slot is consumed this cycle but nothing replaces it yet.
                            F_valid <= 1'b0;
                            req_pc  <= nxt;
                            state   <= S_REQ;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected memory requests
// and expected consumed F slots; a negedge monitor pops and compares them.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  exc;
    } slot_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  stall = 1'b0;
    logic  redirect = 1'b0;
    word_t redirect_pc = '0;
    logic  ack_drv = 1'b0;
    word_t F_PC;
    word_t F_instr;
    logic  F_valid;
    logic  F_exc;

    word_t req_q[$];
    slot_t slot_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    fetch_ctrl_if bus ();

    always #5 clk = ~clk;

    function automatic word_t instr_of(word_t a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_ack   = ack_drv;
    assign bus.imem_rdata = instr_of(bus.imem_addr);

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .F_PC        (F_PC),
        .F_instr     (F_instr),
        .F_valid     (F_valid),
        .F_exc       (F_exc)
    );

    task automatic check(input string name, input logic ok, input word_t act, input word_t exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_req(input word_t a);
        req_q.push_back(a);
    endtask

    task automatic exp_slot(input word_t pc, input logic exc);
        slot_t s;
        s.pc    = pc;
        s.instr = exc ? '0 : instr_of(pc);
        s.exc   = exc;
        slot_q.push_back(s);
    endtask

    task automatic cyc(input logic s, input logic r, input word_t rpc, input logic a);
        @(posedge clk);
        #1;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        ack_drv     = a;
        @(negedge clk);
    endtask

    // Monitor: accepted memory requests and slots consumed by an unstalled D.
    always @(negedge clk) begin
        word_t e;
        slot_t s;
        if (reset) begin
            if (bus.imem_req && bus.imem_ack) begin
                check("req_expected", req_q.size() != 0, bus.imem_addr, '0);
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    check("imem_addr", bus.imem_addr == e, bus.imem_addr, e);
                end
            end
            if (F_valid && !stall) begin
                check("slot_expected", slot_q.size() != 0, F_PC, '0);
                if (slot_q.size() != 0) begin
                    s = slot_q.pop_front();
                    check("F_PC", F_PC == s.pc, F_PC, s.pc);
                    check("F_instr", F_instr == s.instr, F_instr, s.instr);
                    check("F_exc", F_exc == s.exc, word_t'(F_exc), word_t'(s.exc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ack_drv = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", F_valid == 1'b0, word_t'(F_valid), '0);
        check("rst_pc", F_PC == 32'h3000, F_PC, 32'h3000);
        check("rst_req", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);

        // Sequential fetch with zero-wait memory.
        exp_req(32'h3000);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("c1_valid", F_valid == 1'b0, word_t'(F_valid), '0);
        exp_req(32'h3004); exp_slot(32'h3000, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Branch in D while F holds its delay slot.
        exp_req(32'h3100); exp_slot(32'h3004, 1'b0);
        cyc(1'b0, 1'b1, 32'h3100, 1'b1);
        exp_req(32'h3104); exp_slot(32'h3100, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Waited request with two redirects landing before the ack.
        exp_slot(32'h3104, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 32'h3180, 1'b0);
        check("wait_addr", bus.imem_req && bus.imem_addr == 32'h3108, bus.imem_addr, 32'h3108);
        cyc(1'b0, 1'b1, 32'h3200, 1'b0);
        exp_req(32'h3108);
        cyc(1'b0, 1'b0, '0, 1'b1);
        exp_req(32'h3200); exp_slot(32'h3108, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Stall with a redirect held high: nothing moves, redirect ignored.
        repeat (4) begin
            cyc(1'b1, 1'b1, 32'h3400, 1'b1);
            check("stall_req", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);
            check("stall_hold", F_valid && F_PC == 32'h3200, F_PC, 32'h3200);
        end
        exp_req(32'h3204); exp_slot(32'h3200, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);

        // Illegal targets: misaligned, above and below the window, plus both edges.
        exp_slot(32'h3204, 1'b0);
        cyc(1'b0, 1'b1, 32'h3002, 1'b1);
        check("misalign_noreq", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);
        exp_slot(32'h3002, 1'b1);
        cyc(1'b0, 1'b1, 32'h7000, 1'b1);
        check("above_noreq", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);
        exp_req(32'h6FFC); exp_slot(32'h7000, 1'b1);
        cyc(1'b0, 1'b1, 32'h6FFC, 1'b1);
        exp_slot(32'h6FFC, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        check("seq_past_hi_noreq", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);
        exp_req(32'h3000); exp_slot(32'h7000, 1'b1);
        cyc(1'b0, 1'b1, 32'h3000, 1'b1);
        exp_slot(32'h3000, 1'b0);
        cyc(1'b0, 1'b1, 32'h2FFC, 1'b1);
        check("below_noreq", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);

        // Reset while waiting for an ack at 0x3010.
        exp_slot(32'h2FFC, 1'b1);
        cyc(1'b0, 1'b1, 32'h3010, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        check("wait_3010", bus.imem_req && bus.imem_addr == 32'h3010, bus.imem_addr, 32'h3010);
        check("wait_invalid", F_valid == 1'b0, word_t'(F_valid), '0);
        #2 reset = 1'b0;
        ack_drv = 1'b1;
        #1;
        check("async_rst_pc", F_PC == 32'h3000, F_PC, 32'h3000);
        check("async_rst_req", bus.imem_req == 1'b0, word_t'(bus.imem_req), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack_ignored", F_valid == 1'b0, word_t'(F_valid), '0);
        exp_req(32'h3000);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        exp_req(32'h3004); exp_slot(32'h3000, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);

        check("req_q_drained", req_q.size() == 0, word_t'(req_q.size()), '0);
        check("slot_q_drained", slot_q.size() == 0, word_t'(slot_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter IMEM_LO, default 32'h0000_3000, lowest legal fetch address.
REQ-003 Parameter IMEM_HI, default 32'h0000_6FFC, highest legal fetch address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  D stage frozen; held F instruction is not consumed.
REQ-007 redirect  input  1  D-stage branch/jump taken; NPC target valid.
REQ-008 redirect_pc  input  32  target address from NPC.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  request address; word aligned when imem_req=1.
REQ-011 imem_ack  input  1  read data valid this cycle; ignored when imem_req=0.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 F_PC  output  32  PC of held F instruction.
REQ-014 F_instr  output  32  held instruction word.
REQ-015 F_valid  output  1  F_PC/F_instr/F_exc meaningful.
REQ-016 F_exc  output  1  held slot is an address-error fetch (AdEL).

Function
REQ-017 Internal regs: state {S_REQ, S_HOLD}, req_pc[31:0], pend, pend_pc[31:0].
REQ-018 legal(a) = a[1:0]==0 and IMEM_LO <= a <= IMEM_HI; unsigned compare; PC+4 wraps modulo 2^32.
REQ-019 Redirect accepted only when redirect=1 and stall=0; redirect under stall ignored (D re-presents it).
REQ-020 Delay slot: accepted redirect never cancels the held or in-flight F instruction; it selects the address fetched after it.
REQ-021 S_REQ, legal(req_pc): imem_req=1, imem_addr=req_pc; no ack -> stay, outputs unchanged.
REQ-022 S_REQ ack: F_PC<=req_pc, F_instr<=imem_rdata, F_exc<=0, F_valid<=1; req_pc<=pend ? pend_pc : req_pc+4; pend<=0; -> S_HOLD.
REQ-023 S_REQ, !legal(req_pc): imem_req=0; next edge F_PC<=req_pc, F_instr<=0, F_exc<=1, F_valid<=1, same req_pc update as REQ-022; -> S_HOLD.
REQ-024 Accepted redirect in S_REQ without ack: pend<=1, pend_pc<=redirect_pc; a second one overwrites pend_pc.
REQ-025 Accepted redirect in S_REQ with ack same cycle: req_pc<=redirect_pc (overrides pend and +4).
REQ-026 S_HOLD, stall=1: imem_req=0; all outputs held; state unchanged.
REQ-027 S_HOLD, stall=0: next address nxt = redirect accepted ? redirect_pc : req_pc.
REQ-028 S_HOLD, stall=0, legal(nxt): imem_req=1, imem_addr=nxt combinationally; ack -> load F slot from nxt as REQ-022, req_pc<=nxt+4, stay S_HOLD; no ack -> F_valid<=0, req_pc<=nxt, -> S_REQ.
REQ-029 S_HOLD, stall=0, !legal(nxt): imem_req=0; load exception slot from nxt as REQ-023, req_pc<=nxt+4, stay S_HOLD.
REQ-030 Zero-wait memory (ack same cycle) sustains one instruction per cycle.
REQ-031 F_valid=0 only in S_REQ; a stalled D never loses a valid F instruction.

Reset
REQ-032 reset=0 forces immediately: state=S_REQ, req_pc=RESET_PC, pend=0, pend_pc=0, F_PC=RESET_PC, F_instr=0, F_valid=0, F_exc=0.
REQ-033 Reset mid-request abandons it; any ack during reset ignored; first request issued in first cycle after release.

Structure
REQ-034 Shared pipeline package holds state encoding, RESET_PC/IMEM_LO/IMEM_HI defaults, 32-bit word width.
REQ-035 One sub-module, fetch_addr_chk: combinational legal() check, instantiated for req_pc and nxt.

Verification
REQ-036 Reset release, ack every cycle, no stall -> imem_addr 0x3000,0x3004,0x3008 on consecutive cycles; F_valid=1 from cycle 2.
REQ-037 Branch in D with redirect_pc=0x3100 while F holds 0x3004 -> 0x3004 retained as delay slot, next fetch 0x3100.
REQ-038 Redirect to 0x3200 during 3-cycle-wait request for 0x3008 -> 0x3008 delivered, next request 0x3200.
REQ-039 stall=1 for 4 cycles with redirect=1 -> imem_req=0, F outputs constant, redirect ignored.
REQ-040 redirect_pc=0x3002 and 0x7000 -> no imem_req, F_exc=1, F_instr=0, F_PC=target.
REQ-041 reset low while waiting ack at 0x3010 -> F_valid=0 immediately; after release request 0x3000.
